adder_arbiter: RTL and testbench

Round-robin arbiter that shares one saturating unsigned adder (adder_u) among NREQ requesters. Each requester presents an operand pair and holds a request until it receives an acknowledge. The block grants one requester at a time, registers the operands, and evaluates them in the shared adder. It returns the saturated sum, the overflow flag and the requester id with a one-cycle valid/ack pulse. It sits between several datapath clients and the single adder instance.

---
 rtl/adder_arb_pkg.sv | 28 ++
 rtl/adder_arbiter_if.sv | 27 ++
 rtl/adder_u.sv | 17 +
 rtl/adder_arbiter.sv | 79 +++++++
 tb/tb_adder_arbiter.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/adder_arb_pkg.sv
// Shared types and the round-robin winner search for the adder arbiter.
package adder_arb_pkg;

  localparam int unsigned MAX_REQ = 16;
  localparam int unsigned MAX_IDW = 4;

  typedef enum logic [1:0] {IDLE, CALC, RESP} arb_state_t;

  // Scan upward from last_id+1 with wrap-around; bits at or above nreq are ignored.
  function automatic logic [MAX_IDW-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [MAX_IDW-1:0] last_id,
                                                 input int unsigned nreq);
    logic [MAX_IDW-1:0] pick;
    logic               found;
    int unsigned        idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= MAX_REQ; i++) begin
      idx = (32'(last_id) + i) % nreq;
      if (!found && (i <= nreq) && req[idx[MAX_IDW-1:0]]) begin
        pick  = idx[MAX_IDW-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/adder_arbiter_if.sv
// Requester-side bus of the adder arbiter: packed per-requester operands and results.
interface adder_arbiter_if #(
  parameter int unsigned W    = 8,
  parameter int unsigned NREQ = 4
);
  localparam int unsigned IDW = $clog2(NREQ);

  logic [NREQ-1:0]   req_i;
  logic [NREQ*W-1:0] x_i;
  logic [NREQ*W-1:0] y_i;
  logic [NREQ-1:0]   ack_o;
  logic              valid_o;
  logic [W-1:0]      sum_o;
  logic              of_o;
  logic [IDW-1:0]    id_o;
  logic              busy_o;

  modport master (
    output req_i, x_i, y_i,
    input  ack_o, valid_o, sum_o, of_o, id_o, busy_o
  );

  modport slave (
    input  req_i, x_i, y_i,
    output ack_o, valid_o, sum_o, of_o, id_o, busy_o
  );
endinterface

// File: rtl/adder_u.sv
// Saturating unsigned adder: clamps to all-ones and flags overflow when the carry is set.
module adder_u #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W-1:0] sum,
  output logic         of
);
  logic [W:0] full;

  always_comb begin
    full = {1'b0, x} + {1'b0, y};
    of   = full[W];
    sum  = full[W] ? '1 : full[W-1:0];
  end
endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one saturating adder among NREQ requesters.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter int unsigned NREQ = 4
) (
  input logic            clk_i,
  input logic            rst_i,
  adder_arbiter_if.slave bus
);
  localparam int unsigned IDW = $clog2(NREQ);

  arb_state_t      state_q;
  logic [W-1:0]    x_q, y_q, sum_q, add_sum;
  logic            of_q, add_of, valid_q, busy_q;
  logic [IDW-1:0]  id_q, id_out_q, last_id_q, winner;
  logic [NREQ-1:0] ack_q;

  assign winner = IDW'(rr_pick(16'(bus.req_i), 4'(last_id_q), NREQ));

  adder_u #(.W(W)) u_adder (
    .x   (x_q),
    .y   (y_q),
    .sum (add_sum),
    .of  (add_of)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      x_q       <= '0;
      y_q       <= '0;
      id_q      <= '0;
      last_id_q <= IDW'(NREQ - 1);
      ack_q     <= '0;
      valid_q   <= 1'b0;
      sum_q     <= '0;
      of_q      <= 1'b0;
      id_out_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (|bus.req_i) begin
            x_q       <= bus.x_i[winner*W +: W];
            y_q       <= bus.y_i[winner*W +: W];
            id_q      <= winner;
            last_id_q <= winner;
            busy_q    <= 1'b1;
            state_q   <= CALC;
          end
        end
        CALC: begin
          sum_q    <= add_sum;
          of_q     <= add_of;
          id_out_q <= id_q;
          valid_q  <= 1'b1;
          ack_q    <= NREQ'(1) << id_q;
          state_q  <= RESP;
        end
        RESP: begin
          valid_q <= 1'b0;
          ack_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ack_o   = ack_q;
  assign bus.valid_o = valid_q;
  assign bus.sum_o   = sum_q;
  assign bus.of_o    = of_q;
  assign bus.id_o    = id_out_q;
  assign bus.busy_o  = busy_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed self-checking bench for adder_arbiter with W=8, NREQ=4.
module tb_adder_arbiter;
  localparam int unsigned W    = 8;
  localparam int unsigned NREQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_arbiter_if #(.W(W), .NREQ(NREQ)) bus ();

  adder_arbiter #(.W(W), .NREQ(NREQ)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Drive one request from requester n and wait for its result; no comparisons here.
  task automatic run_op(input int n, input logic [W-1:0] x, input logic [W-1:0] y,
                        output logic [NREQ-1:0] ack, output logic [W-1:0] sum,
                        output logic of, output logic [1:0] id, output int cycles);
    bus.x_i[n*W +: W] = x;
    bus.y_i[n*W +: W] = y;
    bus.req_i = NREQ'(1) << n;
    cycles = 0;
    while (!bus.valid_o && cycles < 10) begin
      @(negedge clk);
      cycles++;
    end
    ack = bus.ack_o;
    sum = bus.sum_o;
    of  = bus.of_o;
    id  = bus.id_o;
    bus.req_i = '0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req_i = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_i = 4'b1111;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_tests++;
      if (bus.ack_o !== 4'b0000 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
          bus.sum_o !== 8'd0) begin
        n_fail++;
        $display("FAIL reset: ack=%b valid=%b busy=%b sum=%0d, required 0/0/0/0",
                 bus.ack_o, bus.valid_o, bus.busy_o, bus.sum_o);
      end
    end
    bus.req_i = '0;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    bus.x_i[1*W +: W] = 8'd100;
    bus.y_i[1*W +: W] = 8'd50;
    bus.req_i = 4'b0010;
    @(negedge clk);
    n_tests++;
    if (bus.busy_o !== 1'b1 || bus.valid_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_calc: busy=%b valid=%b, required 1/0", bus.busy_o, bus.valid_o);
    end
    @(negedge clk);
    n_tests++;
    if (bus.ack_o !== 4'b0010 || bus.valid_o !== 1'b1 || bus.id_o !== 2'd1 ||
        bus.sum_o !== 8'd150 || bus.of_o !== 1'b0) begin
      n_fail++;
      $display("FAIL single_resp: ack=%b valid=%b id=%0d sum=%0d of=%b, required 0010/1/1/150/0",
               bus.ack_o, bus.valid_o, bus.id_o, bus.sum_o, bus.of_o);
    end
    bus.req_i = '0;
    @(negedge clk);
    n_tests++;
    if (bus.ack_o !== 4'b0000 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0 ||
        bus.sum_o !== 8'd150) begin
      n_fail++;
      $display("FAIL single_after: ack=%b valid=%b busy=%b sum=%0d, required 0000/0/0/150",
               bus.ack_o, bus.valid_o, bus.busy_o, bus.sum_o);
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0]    xs [3] = '{8'd200, 8'd255, 8'd128};
    logic [W-1:0]    ys [3] = '{8'd100, 8'd0, 8'd127};
    logic            eof[3] = '{1'b1, 1'b0, 1'b0};
    logic [NREQ-1:0] ack;
    logic [W-1:0]    sum;
    logic            of;
    logic [1:0]      id;
    int              cyc;
    for (int k = 0; k < 3; k++) begin
      run_op(0, xs[k], ys[k], ack, sum, of, id, cyc);
      n_tests++;
      if (sum !== 8'd255 || of !== eof[k] || ack !== 4'b0001 || id !== 2'd0 || cyc != 2) begin
        n_fail++;
        $display("FAIL sat_%0d: sum=%0d of=%b ack=%b id=%0d lat=%0d, required 255/%b/0001/0/2",
                 k, sum, of, ack, id, cyc, eof[k]);
      end
    end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] drop;
    int              cyc, cnt, prev;
    do_reset();
    for (int n = 0; n < 4; n++) begin
      bus.x_i[n*W +: W] = W'(n);
      bus.y_i[n*W +: W] = W'(10 * n);
    end
    bus.req_i = 4'b1111;
    drop = '0;
    cyc  = 0;
    cnt  = 0;
    prev = 0;
    while (cnt < 6 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.req_i = bus.req_i | drop;
      drop = '0;
      if (bus.valid_o) begin
        n_tests++;
        if (bus.ack_o !== (NREQ'(1) << (cnt % 4)) || bus.id_o !== 2'(cnt % 4) ||
            bus.sum_o !== 8'(11 * (cnt % 4)) || (cnt > 0 && cyc - prev != 3)) begin
          n_fail++;
          $display("FAIL fair_%0d: ack=%b id=%0d sum=%0d gap=%0d, required id %0d sum %0d gap 3",
                   cnt, bus.ack_o, bus.id_o, bus.sum_o, cyc - prev, cnt % 4, 11 * (cnt % 4));
        end
        prev = cyc;
        drop = bus.ack_o;
        bus.req_i = bus.req_i & ~bus.ack_o;
        cnt++;
      end
    end
    n_tests++;
    if (cnt != 6) begin
      n_fail++;
      $display("FAIL fair_count: acks=%0d, required 6", cnt);
    end
    bus.req_i = '0;
    @(negedge clk);
  endtask

  task automatic test_rotation();
    logic [NREQ-1:0] ack;
    logic [W-1:0]    sum;
    logic            of;
    logic [1:0]      id;
    logic [1:0]      exp_id[2] = '{2'd3, 2'd2};
    int              cyc, cnt;
    do_reset();
    run_op(2, 8'd1, 8'd2, ack, sum, of, id, cyc);
    n_tests++;
    if (id !== 2'd2 || sum !== 8'd3 || ack !== 4'b0100) begin
      n_fail++;
      $display("FAIL rot_first: id=%0d sum=%0d ack=%b, required 2/3/0100", id, sum, ack);
    end
    bus.x_i[3*W +: W] = 8'd7;
    bus.y_i[3*W +: W] = 8'd8;
    bus.req_i = 4'b1100;
    cyc = 0;
    cnt = 0;
    while (cnt < 2 && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.valid_o) begin
        n_tests++;
        if (bus.id_o !== exp_id[cnt]) begin
          n_fail++;
          $display("FAIL rot_%0d: id=%0d, required %0d", cnt, bus.id_o, exp_id[cnt]);
        end
        cnt++;
      end
    end
    n_tests++;
    if (cnt != 2) begin
      n_fail++;
      $display("FAIL rot_count: acks=%0d, required 2", cnt);
    end
    bus.req_i = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_calc();
    int cyc;
    bus.req_i = 4'b1111;
    @(negedge clk);
    n_tests++;
    if (bus.busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstcalc_busy: busy=%b, required 1", bus.busy_o);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_tests++;
    if (bus.ack_o !== 4'b0000 || bus.valid_o !== 1'b0 || bus.busy_o !== 1'b0) begin
      n_fail++;
      $display("FAIL rstcalc_idle: ack=%b valid=%b busy=%b, required 0000/0/0",
               bus.ack_o, bus.valid_o, bus.busy_o);
    end
    cyc = 0;
    while (!bus.valid_o && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (bus.ack_o !== 4'b0001 || bus.id_o !== 2'd0 || cyc != 2) begin
      n_fail++;
      $display("FAIL rstcalc_next: ack=%b id=%0d lat=%0d, required 0001/0/2",
               bus.ack_o, bus.id_o, cyc);
    end
    bus.req_i = '0;
    @(negedge clk);
  endtask

  initial begin
    bus.req_i = '0;
    bus.x_i   = '0;
    bus.y_i   = '0;
    test_reset();
    test_single();
    test_saturation();
    test_fairness();
    test_rotation();
    test_reset_calc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
